// File: rtl/adder_stim_gen.sv
// Operand stimulus generator for the 4-bit adder bench: exhaustive or LFSR sweep,
// one sample strobe per vector. Define ADDER_STIM_CORNER_EN to prefix random runs with corner vectors.
module adder_stim_gen #(
    parameter int          HOLD_CYCLES = 2,
    parameter int          NUM_RANDOM  = 64,
    parameter logic [7:0]  SEED        = 8'hA5
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       mode,
    output logic [3:0] a,
    output logic [3:0] b,
    output logic       vld,
    output logic       sample,
    output logic       busy,
    output logic       done,
    output logic [8:0] count
);

    // state | meaning
    // IDLE  | waiting for start; outputs quiet, count holds last run total
    // HOLD  | a/b driven, counting hold cycles of the current vector
    // FIN   | one-cycle done pulse, busy still high
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HOLD = 2'd1,
        FIN  = 2'd2
    } state_t;

`ifdef ADDER_STIM_CORNER_EN
    localparam int NUM_CORNER = 4;
`else
    localparam int NUM_CORNER = 0;
`endif

    localparam logic [3:0] HOLD_LAST    = 4'(HOLD_CYCLES);
    localparam logic       SAMPLE_FIRST = (HOLD_CYCLES == 1);
    localparam logic [7:0] SEED_EFF     = (SEED == 8'h00) ? 8'h01 : SEED;
    localparam logic [8:0] N_EXH        = 9'd256;
    localparam logic [8:0] N_RND        = 9'(NUM_RANDOM + NUM_CORNER);

    state_t     state;
    logic       mode_r;
    logic [3:0] hold_cnt;
    logic [7:0] lfsr;

    logic [3:0] hold_nxt;
    logic [7:0] next_vec;
    logic [7:0] next_lfsr;
    logic [7:0] first_vec;
    logic [7:0] first_lfsr;
    logic       last_vec;

    function automatic logic [7:0] lfsr_step(input logic [7:0] s);
        return s[0] ? ((s >> 1) ^ 8'hB8) : (s >> 1);
    endfunction

`ifdef ADDER_STIM_CORNER_EN
    function automatic logic [7:0] corner_vec(input logic [1:0] idx);
        logic [7:0] v;
        case (idx)
            2'd0:    v = 8'h00;
            2'd1:    v = 8'hFF;
            2'd2:    v = 8'hF0;
            default: v = 8'h0F;
        endcase
        return v;
    endfunction
`endif

    assign hold_nxt = hold_cnt + 4'd1;
    assign last_vec = (count == (mode_r ? N_RND : N_EXH));

    // count equals the number of the vector on a/b during its last hold cycle,
    // so it also selects the corner entry for the following vector.
    always_comb begin
        next_vec  = {a, b} + 8'd1;
        next_lfsr = lfsr;
        if (mode_r) begin
`ifdef ADDER_STIM_CORNER_EN
            if (count < 9'd4) begin
                next_vec = corner_vec(count[1:0]);
            end else begin
                next_vec  = lfsr;
                next_lfsr = lfsr_step(lfsr);
            end
`else
            next_vec  = lfsr;
            next_lfsr = lfsr_step(lfsr);
`endif
        end
    end

    always_comb begin
        first_vec  = 8'h00;
        first_lfsr = SEED_EFF;
        if (mode) begin
`ifdef ADDER_STIM_CORNER_EN
            first_vec  = 8'h00;
            first_lfsr = SEED_EFF;
`else
            first_vec  = SEED_EFF;
            first_lfsr = lfsr_step(SEED_EFF);
`endif
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            mode_r   <= 1'b0;
            hold_cnt <= 4'd0;
            lfsr     <= 8'h00;
            a        <= 4'd0;
            b        <= 4'd0;
            vld      <= 1'b0;
            sample   <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
            count    <= 9'd0;
        end else begin
            case (state)
                IDLE: begin
                    done   <= 1'b0;
                    sample <= 1'b0;
                    if (start) begin
                        mode_r   <= mode;
                        hold_cnt <= 4'd1;
                        {a, b}   <= first_vec;
                        lfsr     <= first_lfsr;
                        vld      <= 1'b1;
                        busy     <= 1'b1;
                        sample   <= SAMPLE_FIRST;
                        count    <= {8'd0, SAMPLE_FIRST};
                        state    <= HOLD;
                    end
                end
                HOLD: begin
                    if (hold_cnt == HOLD_LAST) begin
                        if (last_vec) begin
                            {a, b} <= 8'h00;
                            vld    <= 1'b0;
                            sample <= 1'b0;
                            done   <= 1'b1;
                            state  <= FIN;
                        end else begin
                            {a, b}   <= next_vec;
                            lfsr     <= next_lfsr;
                            hold_cnt <= 4'd1;
                            sample   <= SAMPLE_FIRST;
                            count    <= count + {8'd0, SAMPLE_FIRST};
                        end
                    end else begin
                        hold_cnt <= hold_nxt;
                        if (hold_nxt == HOLD_LAST) begin
                            sample <= 1'b1;
                            count  <= count + 9'd1;
                        end else begin
                            sample <= 1'b0;
                        end
                    end
                end
                FIN: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    vld    <= 1'b0;
                    sample <= 1'b0;
                    busy   <= 1'b0;
                    done   <= 1'b0;
                    state  <= IDLE;
                end
            endcase
        end
    end

endmodule
